// File: rtl/scytale_decryption_pkg.sv
// rtl/scytale_decryption_pkg.sv - shared constants and FSM states for the decryption stages
package scytale_decryption_pkg;

    localparam int D_WIDTH       = 8;
    localparam int KEY_WIDTH     = 16;
    localparam int MAX_NOF_CHARS = 50;
    localparam logic [7:0] START_DECRYPTION_TOKEN = 8'hFA;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_DECRYPT = 1'b1
    } dec_state_t;

endpackage

// File: rtl/scytale_decryption.sv
// rtl/scytale_decryption.sv - scytale (columnar) decryption stage
module scytale_decryption #(
    parameter int D_WIDTH       = scytale_decryption_pkg::D_WIDTH,
    parameter int KEY_WIDTH     = scytale_decryption_pkg::KEY_WIDTH,
    parameter int MAX_NOF_CHARS = scytale_decryption_pkg::MAX_NOF_CHARS,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = scytale_decryption_pkg::START_DECRYPTION_TOKEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] scytale_key,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 error
);
    import scytale_decryption_pkg::*;

    localparam int CNT_W = $clog2(MAX_NOF_CHARS);
    localparam int HW    = KEY_WIDTH / 2;
    localparam int IDX_W = CNT_W + HW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NOF_CHARS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_NOF_CHARS);

    dec_state_t state, state_nxt;

    logic [D_WIDTH-1:0] mem_q [MAX_NOF_CHARS];
    logic [CNT_W-1:0]   cnt, c, r;
    logic [HW-1:0]      key_n, key_m;
    logic               draining;

    logic [HW-1:0]      sk_n, sk_m;
    logic [2*HW-1:0]    key_prod;
    logic               key_bad;
    logic               tok_hit, chr_hit;
    logic [IDX_W-1:0]   idx_full;
    logic [D_WIDTH-1:0] rd_data;
    logic               c_last, r_last;

    assign sk_n     = scytale_key[KEY_WIDTH-1:HW];
    assign sk_m     = scytale_key[HW-1:0];
    assign key_prod = {{HW{1'b0}}, sk_n} * {{HW{1'b0}}, sk_m};
    assign key_bad  = (sk_n == '0) || (sk_m == '0) ||
                      (key_prod != {{(2*HW-CNT_W){1'b0}}, cnt});

    assign tok_hit = (state == ST_IDLE) && valid_i && (data_i == START_DECRYPTION_TOKEN);
    assign chr_hit = (state == ST_IDLE) && valid_i && (data_i != START_DECRYPTION_TOKEN);

    // Read index c*M + r at full width; guarded so a bad index can never address past the buffer
    assign idx_full = {{HW{1'b0}}, c} * {{CNT_W{1'b0}}, key_m} + {{HW{1'b0}}, r};
    assign rd_data  = (idx_full < IDX_MAX) ? mem_q[idx_full[CNT_W-1:0]] : '0;
    assign c_last   = ({{HW{1'b0}}, c} + IDX_W'(1)) == {{CNT_W{1'b0}}, key_n};
    assign r_last   = ({{HW{1'b0}}, r} + IDX_W'(1)) == {{CNT_W{1'b0}}, key_m};

    assign busy = (state == ST_DECRYPT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (tok_hit) state_nxt = ST_DECRYPT;
            ST_DECRYPT: if (error || draining) state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (chr_hit && (cnt < CNT_MAX)) mem_q[cnt] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            c        <= '0;
            r        <= '0;
            key_n    <= '0;
            key_m    <= '0;
            draining <= 1'b0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            error    <= 1'b0;
        end else if (state == ST_IDLE) begin
            valid_o  <= 1'b0;
            data_o   <= '0;
            error    <= 1'b0;
            draining <= 1'b0;
            if (tok_hit) begin
                key_n <= sk_n;
                key_m <= sk_m;
                error <= key_bad;
            end else if (chr_hit && (cnt < CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (error || draining) begin
            // Error pulse or final character already shown: close the message
            error    <= 1'b0;
            draining <= 1'b0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            cnt      <= '0;
            c        <= '0;
            r        <= '0;
        end else begin
            valid_o <= 1'b1;
            data_o  <= rd_data;
            if (c_last) begin
                c <= '0;
                r <= r + CNT_W'(1);
                if (r_last) draining <= 1'b1;
            end else begin
                c <= c + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_scytale_decryption.sv
// tb/tb_scytale_decryption.sv - directed self-checking bench for scytale_decryption
module tb_scytale_decryption;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] scytale_key;
    logic        busy;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        error;

    int checks;
    int failures;

    int         nout, nerr, first_valid, last_valid, busy_fall, bad_zero, err_first;
    logic       busy1;
    logic [7:0] got [64];

    scytale_decryption dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .scytale_key (scytale_key),
        .busy        (busy),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_char(input logic [7:0] d);
        @(negedge clk);
        data_i  = d;
        valid_i = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    // Samples ncyc negedges after the token; optionally pokes valid_i while busy
    task automatic capture(input int ncyc, input bit noise, input logic [15:0] key_after);
        nout = 0; nerr = 0; first_valid = -1; last_valid = -1;
        busy_fall = -1; bad_zero = 0; err_first = -1; busy1 = 1'b0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (i == 1) busy1 = busy;
            if (valid_o === 1'b1) begin
                if (nout < 64) got[nout] = data_o;
                nout++;
                if (first_valid < 0) first_valid = i;
                last_valid = i;
            end else if (data_o !== 8'h00) begin
                bad_zero++;
            end
            if (error === 1'b1) begin
                nerr++;
                if (err_first < 0) err_first = i;
            end
            if (busy !== 1'b1 && busy_fall < 0) busy_fall = i;
            if (i == 1) scytale_key = key_after;
            if (noise && busy === 1'b1) begin
                valid_i = 1'b1;
                data_i  = i[0] ? 8'hFA : 8'h5A;
            end else begin
                valid_i = 1'b0;
                data_i  = 8'h00;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; valid_i = 1'b0; data_i = 8'h00; scytale_key = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data_o); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b want=0", error); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_2x3;
        string exp = "ABCDEF";
        scytale_key = {8'd2, 8'd3};
        send_str("ACEBDF");
        send_char(8'hFA);
        capture(12, 1'b1, {8'd2, 8'd3});
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b want=1", busy1); end
        checks++; if (first_valid != 2) begin failures++; $display("FAIL basic_first_valid got=%0d want=2", first_valid); end
        checks++; if (nout != 6) begin failures++; $display("FAIL basic_nout got=%0d want=6", nout); end
        checks++; if (last_valid != 7) begin failures++; $display("FAIL basic_last_valid got=%0d want=7", last_valid); end
        checks++; if (busy_fall != 8) begin failures++; $display("FAIL basic_busy_fall got=%0d want=8", busy_fall); end
        checks++; if (nerr != 0) begin failures++; $display("FAIL basic_error got=%0d want=0", nerr); end
        checks++; if (bad_zero != 0) begin failures++; $display("FAIL basic_idle_data got=%0d want=0", bad_zero); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin failures++; $display("FAIL basic_char%0d got=%h want=%h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_transposed_3x2;
        string exp = "ABCDEF";
        scytale_key = {8'd3, 8'd2};
        send_str("ADBECF");
        send_char(8'hFA);
        capture(12, 1'b0, 16'h0000);
        checks++; if (nout != 6) begin failures++; $display("FAIL trans_nout got=%0d want=6", nout); end
        checks++; if (nerr != 0) begin failures++; $display("FAIL trans_error got=%0d want=0", nerr); end
        checks++; if (first_valid != 2) begin failures++; $display("FAIL trans_first_valid got=%0d want=2", first_valid); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin failures++; $display("FAIL trans_char%0d got=%h want=%h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_mismatch;
        string exp = "ABC";
        scytale_key = {8'd2, 8'd2};
        send_str("VWXYZ");
        send_char(8'hFA);
        capture(6, 1'b0, {8'd2, 8'd2});
        checks++; if (nerr != 1) begin failures++; $display("FAIL mism_error_cycles got=%0d want=1", nerr); end
        checks++; if (err_first != 1) begin failures++; $display("FAIL mism_error_when got=%0d want=1", err_first); end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL mism_busy got=%b want=1", busy1); end
        checks++; if (nout != 0) begin failures++; $display("FAIL mism_nout got=%0d want=0", nout); end
        checks++; if (busy_fall != 2) begin failures++; $display("FAIL mism_busy_fall got=%0d want=2", busy_fall); end
        scytale_key = {8'd3, 8'd1};
        send_str("ABC");
        send_char(8'hFA);
        capture(8, 1'b0, {8'd3, 8'd1});
        checks++; if (nout != 3) begin failures++; $display("FAIL recover_nout got=%0d want=3", nout); end
        checks++; if (nerr != 0) begin failures++; $display("FAIL recover_error got=%0d want=0", nerr); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin failures++; $display("FAIL recover_char%0d got=%h want=%h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_zero_key;
        scytale_key = {8'd0, 8'd4};
        send_char(8'hFA);
        capture(4, 1'b0, {8'd0, 8'd4});
        checks++; if (nerr != 1) begin failures++; $display("FAIL zerokey_error got=%0d want=1", nerr); end
        checks++; if (nout != 0) begin failures++; $display("FAIL zerokey_nout got=%0d want=0", nout); end
        checks++; if (busy_fall != 2) begin failures++; $display("FAIL zerokey_busy_fall got=%0d want=2", busy_fall); end
        scytale_key = {8'd2, 8'd2};
        send_char(8'hFA);
        capture(4, 1'b0, {8'd2, 8'd2});
        checks++; if (nerr != 1) begin failures++; $display("FAIL empty_msg_error got=%0d want=1", nerr); end
        checks++; if (nout != 0) begin failures++; $display("FAIL empty_msg_nout got=%0d want=0", nout); end
    endtask

    task automatic test_overflow;
        logic [7:0] want;
        scytale_key = {8'd5, 8'd10};
        for (int i = 0; i < 55; i++) send_char(8'(i + 1));
        send_char(8'hFA);
        capture(60, 1'b0, {8'd5, 8'd10});
        checks++; if (nout != 50) begin failures++; $display("FAIL ovf_nout got=%0d want=50", nout); end
        checks++; if (nerr != 0) begin failures++; $display("FAIL ovf_error got=%0d want=0", nerr); end
        checks++; if (busy_fall != 52) begin failures++; $display("FAIL ovf_busy_fall got=%0d want=52", busy_fall); end
        for (int j = 0; j < 50; j++) begin
            want = 8'((j % 5) * 10 + j / 5 + 1);
            checks++;
            if (got[j] !== want) begin failures++; $display("FAIL ovf_char%0d got=%h want=%h", j, got[j], want); end
        end
    endtask

    task automatic test_reset_mid;
        string exp = "ABCDEF";
        scytale_key = {8'd2, 8'd3};
        send_str("ACEBDF");
        send_char(8'hFA);
        capture(4, 1'b0, {8'd2, 8'd3});
        checks++; if (nout != 3) begin failures++; $display("FAIL mid_nout_before got=%0d want=3", nout); end
        checks++; if (got[2] !== 8'h43) begin failures++; $display("FAIL mid_third_char got=%h want=43", got[2]); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", valid_o); end
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h want=00", data_o); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL mid_rst_error got=%b want=0", error); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scytale_key = {8'd3, 8'd2};
        send_str("ADBECF");
        send_char(8'hFA);
        capture(10, 1'b0, {8'd3, 8'd2});
        checks++; if (nout != 6) begin failures++; $display("FAIL mid_new_nout got=%0d want=6", nout); end
        checks++; if (nerr != 0) begin failures++; $display("FAIL mid_new_error got=%0d want=0", nerr); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin failures++; $display("FAIL mid_new_char%0d got=%h want=%h", k, got[k], exp[k]); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_2x3();
        test_transposed_3x2();
        test_mismatch();
        test_zero_key();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
